// File: rtl/counterdown16_1clk_async_resetn.sv
// Loadable down counter with a one-cycle terminal-count pulse.
// It runs in one-shot or auto-reload mode and is sequenced by a small IDLE/RUN/DONE controller.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | after reset; waits for the first load, count held at 0
// ST_RUN  | counting down on enabled ticks; reloads or finishes at 0
// ST_DONE | one-shot finished or loaded with 0; count held until load
module counterdown16_1clk_async_resetn #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != '0) ? ST_RUN : ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          count_d = count_q;
        end
        ST_RUN: begin
          if (enable) begin
            if (count_q > CNT_ONE) begin
              count_d = count_q - CNT_ONE;
            end else if (count_q == CNT_ONE) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else if (auto_reload) begin
              // The zero cycle is part of the period, hence reload_q+1 ticks.
              count_d = reload_q;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign tc    = tc_q;
  assign busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_counterdown16_1clk_async_resetn.sv
// Scoreboard bench for the down counter.
// The driver predicts each cycle from a behavioural model, and the monitor compares the DUT outputs against it.
module tb_counterdown16_1clk_async_resetn;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        enable = 1'b0;
  logic        auto_reload = 1'b0;
  logic [15:0] count;
  logic        zero, tc, busy;

  counterdown16_1clk_async_resetn #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .auto_reload(auto_reload),
    .count(count), .zero(zero), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] count;
    logic        zero;
    logic        tc;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  event async_chk;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: plain integers and a "running" flag
  int m_count  = 0;
  int m_reload = 0;
  bit m_running = 0;
  bit m_tc = 0;

  function automatic void push_expected();
    exp_t e;
    e.count = 16'(m_count);
    e.zero  = (m_count == 0);
    e.tc    = m_tc;
    e.busy  = m_running;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_count = 0; m_reload = 0; m_running = 0; m_tc = 0;
  endfunction

  function automatic void model_edge(bit ld, int lv, bit en, bit ar);
    m_tc = 0;
    if (ld) begin
      m_count = lv; m_reload = lv; m_running = (lv != 0);
    end else if (m_running && en) begin
      if (m_count >= 2) m_count = m_count - 1;
      else if (m_count == 1) begin m_count = 0; m_tc = 1; end
      else if (ar) m_count = m_reload;
      else m_running = 0;
    end
  endfunction

  task automatic cyc(input bit r, input bit ld, input int lv, input bit en, input bit ar);
    bit asserting;
    @(negedge clk);
    #1;
    asserting = reset && !r;
    reset = r; load = ld; load_value = 16'(lv); enable = en; auto_reload = ar;
    if (asserting) begin
      model_reset();
      #1;
      push_expected();
      -> async_chk;
    end
    @(posedge clk);
    if (!r) model_reset();
    else model_edge(ld, lv, en, ar);
    push_expected();
  endtask

  task automatic check1(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or async_chk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check1("count", count, e.count);
        check1("zero", {15'd0, zero}, {15'd0, e.zero});
        check1("tc", {15'd0, tc}, {15'd0, e.tc});
        check1("busy", {15'd0, busy}, {15'd0, e.busy});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin : driver
    int guard;
    // reset held, then idle with enable and no load
    repeat (3) cyc(0, 0, 0, 1, 0);
    repeat (10) cyc(1, 0, 0, 1, 0);

    // one-shot
    cyc(1, 1, 5, 1, 0);
    repeat (17) cyc(1, 0, 0, 1, 0);

    // periodic
    cyc(1, 1, 3, 1, 1);
    repeat (12) cyc(1, 0, 0, 1, 1);

    // gapped enable
    cyc(1, 1, 4, 0, 0);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, (i % 2) == 0, 0);

    // load wins over the 1->0 tick
    cyc(1, 1, 4, 1, 0);
    guard = 0;
    while (m_count != 1 && guard < 20) begin cyc(1, 0, 0, 1, 0); guard++; end
    cyc(1, 1, 16'h0010, 1, 0);
    repeat (3) cyc(1, 0, 0, 1, 0);

    // load zero goes straight to done
    cyc(1, 1, 0, 1, 1);
    repeat (3) cyc(1, 0, 0, 1, 1);

    // asynchronous reset mid-run
    cyc(1, 1, 16'h1236, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (5) cyc(1, 0, 0, 1, 0);

    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, en, ar;
      int lv;
      r  = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 11) == 0);
      lv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 9));
      en = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1);
      cyc(r, ld, lv, en, ar);
    end

    // maximum load value, one-shot
    cyc(1, 1, 16'hFFFF, 1, 0);
    repeat (65540) cyc(1, 0, 0, 1, 0);

    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counterdown16_1clk_async_resetn.md
# counterdown16_1clk_async_resetn

Loadable 16-bit down counter with terminal-count pulse, one-shot and auto-reload modes. It is the counting-down counterpart of the family's up counters, used as a programmable interval timer or delay generator next to them in the simple-registers suite. A three-state controller (IDLE, RUN, DONE) sequences load, decrement, terminal count and reload.

## Interface
Parameters:
- WIDTH, 16, counter and load-value width.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  reset, asynchronous, active-low; reset=0 clears all state immediately.
- load  input  1  synchronous load strobe; takes priority over enable.
- load_value  input  WIDTH  value captured into count and the reload register on load.
- enable  input  1  count tick qualifier; count changes only on edges with enable=1, except on load.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot. Sampled on each tick, not latched.
- count  output  WIDTH  current counter value, registered.
- zero  output  1  count==0; decoded from the count register, so it adds no extra latency.
- tc  output  1  terminal-count pulse, registered, high for exactly one cycle.
- busy  output  1  1 while state==RUN.

## Operation
- Internal state: count, reload_reg[WIDTH-1:0], a two-bit state register, and the tc register.
- Reset (reset=0, asynchronous) sets state=IDLE, count=0, reload_reg=0 and tc=0, so zero=1 and busy=0. This holds for as long as reset=0. After release, the block stays in IDLE until a load.
- load=1, in any state, at the next edge:
  - count←load_value and reload_reg←load_value; tc←0.
  - State goes to RUN if load_value≠0, otherwise to DONE.
  - enable is ignored on that edge.
- IDLE or DONE with load=0: count holds and tc=0, whatever enable is.
- RUN, enable=0, load=0: count holds and tc=0.
- RUN, enable=1, load=0:
  - count>1: count←count-1, tc←0.
  - count==1: count←0, tc←1, and the state stays RUN.
  - count==0 and auto_reload=1: count←reload_reg, tc←0, stay RUN.
  - count==0 and auto_reload=0: state←DONE, count stays 0, tc←0.
- Periodic period is reload_reg+1 enabled ticks, and tc fires once per period.
- Arithmetic is unsigned WIDTH-bit. Decrement never goes below 0, so there is no wrap to all-ones.
- Load and reset never assert tc.
- Unused state encoding recovers to IDLE on the next edge with count←0.

## Timing
- All outputs are registered, or decoded directly from registers (zero, busy). There is no combinational input-to-output path.
- Load latency: 1 edge. count=load_value in the cycle after the load edge.
- tc is high in the same cycle that count first shows 0 after a 1→0 tick. It drops on the next edge regardless of enable.
- One-shot: busy stays 1 while count==0 after terminal count. It falls on the next enabled tick, when the state goes to DONE.
- Reset assertion clears outputs without a clock edge. Release is synchronous to clk; the first state change is possible on the first edge after release.
- Simultaneous events:
  - load beats enable and beats terminal count.
  - A load on the tick where count==1 gives count=load_value and no tc pulse.
  - reset beats everything.

## Test plan
- Reset/idle: pulse reset=0 for 3 cycles, then hold enable=1 for 10 cycles with no load → count=0, zero=1, tc=0, busy=0 throughout.
- One-shot: load 5, auto_reload=0, enable=1 continuous → count 5,4,3,2,1,0. tc=1 only in the count=0 cycle; busy falls one cycle later; count stays 0 for 10 more cycles with no further tc.
- Periodic: load 3, auto_reload=1, enable=1 → count 3,2,1,0,3,2,1,0,3. tc high every 4th cycle, aligned with count=0; busy stays 1.
- Gapped enable and load override: load 4, toggle enable 1/0 each cycle → each value is held 2 cycles and tc pulses once. Repeat with load=0x0010 asserted at count=1 → next count=0x0010 and no tc. Load 0 → state DONE, zero=1, busy=0, tc=0.
- Async reset mid-run: at count=0x1234 with enable=1, drive reset=0 between edges → count=0, busy=0, tc=0 before the next edge. After release, count stays 0.
- Max value: load 0xFFFF in one-shot mode → exactly 65535 enabled ticks until count=0, with a single tc pulse.
